// File: rtl/key_debounce_if.sv
// Button-side bundle for key_debounce: raw key in, debounced level and strobes out.
// KEY_DEBOUNCE_RELEASE_PULSE_EN adds the release strobe.
interface key_debounce_if;
    logic key;
    logic key_pulse;
    logic key_state;
`ifdef KEY_DEBOUNCE_RELEASE_PULSE_EN
    logic key_release_pulse;

    modport slave  (input  key, output key_pulse, key_state, key_release_pulse);
    modport master (output key, input  key_pulse, key_state, key_release_pulse);
`else
    modport slave  (input  key, output key_pulse, key_state);
    modport master (output key, input  key_pulse, key_state);
`endif
endinterface

// File: rtl/key_debounce.sv
// Push-button cleaner: 2-flop synchroniser, stability counter, one strobe per accepted press.
// Define KEY_DEBOUNCE_RELEASE_PULSE_EN to also strobe on accepted release.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic          clk,
    input  logic          rst,
    key_debounce_if.slave kbus
);
    localparam int               CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_state;
    logic             r_pulse;
    logic [CNT_W-1:0] r_cnt;
    logic             w_diff;
    logic             w_accept;

    assign w_diff   = (r_sync2 != r_state);
    assign w_accept = w_diff && (r_cnt == LAST);

    // Any sample matching the current level restarts the interval.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_state <= 1'b0;
            r_pulse <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= kbus.key;
            r_sync2 <= r_sync1;
            r_pulse <= w_accept && r_sync2;
            if (!w_diff) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_state <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign kbus.key_pulse = r_pulse;
    assign kbus.key_state = r_state;

`ifdef KEY_DEBOUNCE_RELEASE_PULSE_EN
    logic r_rel_pulse;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_rel_pulse <= 1'b0;
        else     r_rel_pulse <= w_accept && !r_sync2;
    end

    assign kbus.key_release_pulse = r_rel_pulse;
`endif
endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce at DEBOUNCE_CYCLES = 4, with a DEBOUNCE_CYCLES = 1
// instance sharing the same key stimulus.
module tb_key_debounce;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   np     = 0;
    int   np1    = 0;
    int   nrel   = 0;

    key_debounce_if bus ();
    key_debounce_if bus1 ();
    assign bus1.key = bus.key;

    key_debounce #(.DEBOUNCE_CYCLES(4)) dut  (.clk(clk), .rst(rst), .kbus(bus));
    key_debounce #(.DEBOUNCE_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .kbus(bus1));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.key_pulse)  np++;
        if (bus1.key_pulse) np1++;
`ifdef KEY_DEBOUNCE_RELEASE_PULSE_EN
        if (bus.key_release_pulse) nrel++;
`endif
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        // 1: reset held with key pressed, then release of reset counts as a new press
        bus.key = 1'b1;
        ticks(4);
        chk("rst_state", 32'(bus.key_state), 0);
        chk("rst_pulse", 32'(bus.key_pulse), 0);
        chk("rst_npulse", 32'(np), 0);
        rst = 1'b0;
        ticks(5);
        chk("t1_pre_state", 32'(bus.key_state), 0);
        chk("t1_pre_np", 32'(np), 0);
        tick();
        chk("t1_pulse", 32'(bus.key_pulse), 1);
        chk("t1_state", 32'(bus.key_state), 1);
        ticks(10);
        chk("t1_np", 32'(np), 1);
        chk("t1_np_d1", 32'(np1), 1);

        // 2: clean press held 50 cycles, then release
        bus.key = 1'b0;
        ticks(8);
        chk("t2_idle_state", 32'(bus.key_state), 0);
        np = 0; np1 = 0; nrel = 0;
        bus.key = 1'b1;
        ticks(5);
        chk("t2_pre_state", 32'(bus.key_state), 0);
        tick();
        chk("t2_pulse", 32'(bus.key_pulse), 1);
        chk("t2_state", 32'(bus.key_state), 1);
        tick();
        chk("t2_pulse_width", 32'(bus.key_pulse), 0);
        ticks(48);
        chk("t2_np", 32'(np), 1);
        chk("t2_np_d1", 32'(np1), 1);
        chk("t2_held_state", 32'(bus.key_state), 1);
        bus.key = 1'b0;
        ticks(5);
        chk("t2_rel_pre_state", 32'(bus.key_state), 1);
        tick();
        chk("t2_rel_state", 32'(bus.key_state), 0);
`ifdef KEY_DEBOUNCE_RELEASE_PULSE_EN
        chk("t2_rel_pulse", 32'(bus.key_release_pulse), 1);
`endif
        ticks(4);
        chk("t2_rel_np", 32'(np), 1);
`ifdef KEY_DEBOUNCE_RELEASE_PULSE_EN
        chk("t2_nrel", 32'(nrel), 1);
`endif

        // 3: bounce 1,0,1,0 every 2 cycles, then stable 1
        np = 0;
        for (int i = 0; i < 2; i++) begin
            bus.key = 1'b1; ticks(2);
            bus.key = 1'b0; ticks(2);
        end
        chk("t3_bounce_np", 32'(np), 0);
        chk("t3_bounce_state", 32'(bus.key_state), 0);
        bus.key = 1'b1;
        ticks(5);
        chk("t3_pre_np", 32'(np), 0);
        tick();
        chk("t3_pulse", 32'(bus.key_pulse), 1);
        bus.key = 1'b0;
        ticks(10);
        chk("t3_np", 32'(np), 1);

        // 4: 3-cycle glitch is one short of the interval
        np = 0;
        bus.key = 1'b1; ticks(3);
        bus.key = 1'b0; ticks(10);
        chk("t4_np", 32'(np), 0);
        chk("t4_state", 32'(bus.key_state), 0);

        // 5: press, release 10 cycles, press again
        np = 0; np1 = 0; nrel = 0;
        bus.key = 1'b1; ticks(20);
        bus.key = 1'b0; ticks(10);
        chk("t5_mid_state", 32'(bus.key_state), 0);
        bus.key = 1'b1; ticks(20);
        chk("t5_np", 32'(np), 2);
        chk("t5_np_d1", 32'(np1), 2);
        chk("t5_state", 32'(bus.key_state), 1);
`ifdef KEY_DEBOUNCE_RELEASE_PULSE_EN
        chk("t5_nrel", 32'(nrel), 1);
`endif
        bus.key = 1'b0; ticks(10);

        // 6: async reset two cycles into a press interval
        np = 0;
        bus.key = 1'b1;
        ticks(3);
        chk("t6_cnt_before", 32'(dut.r_cnt), 1);
        rst = 1'b1;
        #1;
        chk("t6_cnt_async", 32'(dut.r_cnt), 0);
        chk("t6_state_async", 32'(bus.key_state), 0);
        ticks(3);
        rst = 1'b0;
        ticks(5);
        chk("t6_pre_np", 32'(np), 0);
        chk("t6_pre_state", 32'(bus.key_state), 0);
        tick();
        chk("t6_pulse", 32'(bus.key_pulse), 1);
        ticks(5);
        rst = 1'b1;
        #1;
        chk("t6_held_rst_state", 32'(bus.key_state), 0);
        ticks(2);
        rst = 1'b0;
        np = 0;
        ticks(5);
        chk("t6_repress_pre_np", 32'(np), 0);
        tick();
        chk("t6_repress_pulse", 32'(bus.key_pulse), 1);
        chk("t6_repress_state", 32'(bus.key_state), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
